mem_req_arbiter: RTL

Sequences cache-side memory requests onto the single read port and single write port of the AXI bridge. The instruction-cache refill and data-cache refill/uncached-load requesters share one read port. The arbiter gives data reads fixed priority with a starvation bound for instruction reads. It also holds back any data read that hits the cache line of a write-back that has not yet been acknowledged. Sits between the L1 cache controllers and the AXI bridge.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_req_arbiter_if.sv | 68 ++++++
 rtl/mem_arb_grant.sv | 43 ++++
 rtl/mem_req_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter: read-port FSM states,
// read ID encoding and the default cache-line offset.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_IC   = 2'd1,
        R_DC   = 2'd2
    } rd_state_e;

    localparam logic ID_IC = 1'b0;
    localparam logic ID_DC = 1'b1;

    localparam int unsigned LINE_OFF_DEFAULT = 6;

    // icache refills always use 4-byte beats
    localparam logic [2:0] IC_RSIZE = 3'd2;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned GNT_IC = 0;
    localparam int unsigned GNT_DC = 1;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the cache-side request/response signals and the AXI-bridge read/write port.
// slave: the arbiter's view; master: the cache controllers and bridge that surround it.
interface mem_req_arbiter_if;

    logic         ic_rvalid;
    logic [31:0]  ic_raddr;
    logic [7:0]   ic_rlen;
    logic [511:0] ic_rdata;
    logic         ic_rready;

    logic         dc_rvalid;
    logic [31:0]  dc_raddr;
    logic [7:0]   dc_rlen;
    logic [2:0]   dc_rsize;
    logic [511:0] dc_rdata;
    logic         dc_rready;

    logic         dc_wvalid;
    logic [31:0]  dc_waddr;
    logic [511:0] dc_wdata;
    logic [7:0]   dc_wlen;
    logic [2:0]   dc_wsize;
    logic [3:0]   dc_wstrb;
    logic         dc_wready;

    logic         m_rvalid;
    logic [31:0]  m_raddr;
    logic [7:0]   m_rlen;
    logic [2:0]   m_rsize;
    logic         m_rid;
    logic [511:0] m_rdata;
    logic         m_rready;

    logic         m_wvalid;
    logic [31:0]  m_waddr;
    logic [511:0] m_wdata;
    logic [7:0]   m_wlen;
    logic [2:0]   m_wsize;
    logic [3:0]   m_wstrb;
    logic         m_wready;

    modport slave (
        input  ic_rvalid, ic_raddr, ic_rlen,
        output ic_rdata, ic_rready,
        input  dc_rvalid, dc_raddr, dc_rlen, dc_rsize,
        output dc_rdata, dc_rready,
        input  dc_wvalid, dc_waddr, dc_wdata, dc_wlen, dc_wsize, dc_wstrb,
        output dc_wready,
        output m_rvalid, m_raddr, m_rlen, m_rsize, m_rid,
        input  m_rdata, m_rready,
        output m_wvalid, m_waddr, m_wdata, m_wlen, m_wsize, m_wstrb,
        input  m_wready
    );

    modport master (
        output ic_rvalid, ic_raddr, ic_rlen,
        input  ic_rdata, ic_rready,
        output dc_rvalid, dc_raddr, dc_rlen, dc_rsize,
        input  dc_rdata, dc_rready,
        output dc_wvalid, dc_waddr, dc_wdata, dc_wlen, dc_wsize, dc_wstrb,
        input  dc_wready,
        input  m_rvalid, m_raddr, m_rlen, m_rsize, m_rid,
        output m_rdata, m_rready,
        input  m_wvalid, m_waddr, m_wdata, m_wlen, m_wsize, m_wstrb,
        output m_wready
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Read-port grant select: dcache first, icache forced through once it has watched
// STARVE_LIMIT consecutive dcache grants.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       ic_rvalid,
    input  logic       dc_rvalid,
    input  logic       hazard,
    input  rd_state_e  state,
    output logic [1:0] grant,
    output logic [3:0] starve_cnt
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    always_comb begin
        grant = '0;
        if (state == R_IDLE) begin
            if (ic_rvalid && starve_cnt == Limit) begin
                grant[GNT_IC] = 1'b1;
            end else if (dc_rvalid && !hazard) begin
                grant[GNT_DC] = 1'b1;
            end else if (ic_rvalid) begin
                grant[GNT_IC] = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            starve_cnt <= '0;
        end else if (grant[GNT_IC]) begin
            starve_cnt <= '0;
        end else if (grant[GNT_DC] && ic_rvalid && starve_cnt != Limit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Sequences icache/dcache reads onto the bridge read port and passes write-backs through,
// stalling dcache reads that hit the line of an unacknowledged write. Optional counters: ARB_PERF_CNT_EN.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LINE_OFF     = LINE_OFF_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    mem_req_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_ic_grant,
    output logic [31:0]       perf_dc_grant,
    output logic [31:0]       perf_haz_stall
`endif
);

    localparam int unsigned TagW = 32 - LINE_OFF;

    rd_state_e       state;
    logic [1:0]      grant;
    logic [3:0]      starve_cnt;
    logic            hazard;
    logic            w_pend;
    logic [TagW-1:0] w_tag;
    logic [TagW-1:0] rd_tag;
    logic [TagW-1:0] wr_tag;

    logic            rvalid_q;
    logic [31:0]     raddr_q;
    logic [7:0]      rlen_q;
    logic [2:0]      rsize_q;
    logic            rid_q;

    assign rd_tag = bus.dc_raddr[31:LINE_OFF];
    assign wr_tag = bus.dc_waddr[31:LINE_OFF];

    // A write offered in the same cycle counts as in flight even before w_pend sets
    always_comb begin
        hazard = 1'b0;
        if (bus.dc_rvalid) begin
            hazard = w_pend ? (rd_tag == w_tag) : (bus.dc_wvalid && (rd_tag == wr_tag));
        end
    end

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .ic_rvalid  (bus.ic_rvalid),
        .dc_rvalid  (bus.dc_rvalid),
        .hazard     (hazard),
        .state      (state),
        .grant      (grant),
        .starve_cnt (starve_cnt)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= R_IDLE;
            rvalid_q <= 1'b0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rsize_q  <= '0;
            rid_q    <= 1'b0;
        end else begin
            unique case (state)
                R_IDLE: begin
                    if (grant[GNT_IC]) begin
                        state    <= R_IC;
                        rvalid_q <= 1'b1;
                        raddr_q  <= bus.ic_raddr;
                        rlen_q   <= bus.ic_rlen;
                        rsize_q  <= IC_RSIZE;
                        rid_q    <= ID_IC;
                    end else if (grant[GNT_DC]) begin
                        state    <= R_DC;
                        rvalid_q <= 1'b1;
                        raddr_q  <= bus.dc_raddr;
                        rlen_q   <= bus.dc_rlen;
                        rsize_q  <= bus.dc_rsize;
                        rid_q    <= ID_DC;
                    end
                end
                R_IC, R_DC: begin
                    if (bus.m_rready) begin
                        state    <= R_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= R_IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_pend <= 1'b0;
            w_tag  <= '0;
        end else if (bus.m_wready) begin
            w_pend <= 1'b0;
        end else if (bus.dc_wvalid && !w_pend) begin
            w_pend <= 1'b1;
            w_tag  <= wr_tag;
        end
    end

    assign bus.m_rvalid  = rvalid_q;
    assign bus.m_raddr   = raddr_q;
    assign bus.m_rlen    = rlen_q;
    assign bus.m_rsize   = rsize_q;
    assign bus.m_rid     = rid_q;

    assign bus.ic_rdata  = bus.m_rdata;
    assign bus.dc_rdata  = bus.m_rdata;
    assign bus.ic_rready = bus.m_rready && (state == R_IC);
    assign bus.dc_rready = bus.m_rready && (state == R_DC);

    assign bus.m_wvalid  = bus.dc_wvalid;
    assign bus.m_waddr   = bus.dc_waddr;
    assign bus.m_wdata   = bus.dc_wdata;
    assign bus.m_wlen    = bus.dc_wlen;
    assign bus.m_wsize   = bus.dc_wsize;
    assign bus.m_wstrb   = bus.dc_wstrb;
    assign bus.dc_wready = bus.m_wready;

    // The grant logic never lets the counter pass the limit
    starve_in_range: assert property (@(posedge aclk) disable iff (!aresetn)
        starve_cnt <= 4'(STARVE_LIMIT));

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            perf_ic_grant  <= '0;
            perf_dc_grant  <= '0;
            perf_haz_stall <= '0;
        end else begin
            if (grant[GNT_IC]) perf_ic_grant <= perf_ic_grant + 32'd1;
            if (grant[GNT_DC]) perf_dc_grant <= perf_dc_grant + 32'd1;
            if (state == R_IDLE && hazard) perf_haz_stall <= perf_haz_stall + 32'd1;
        end
    end
`endif

endmodule
